// File: rtl/viterbi_pkg.sv
// Shared code constants for the Viterbi transmit/decode pair.
// The decoder imports the same G0/G1 generator taps.
package viterbi_pkg;
  localparam int K = 3;
  localparam logic [K-1:0] G0 = 3'b111;
  localparam logic [K-1:0] G1 = 3'b101;
  localparam int SYM_W = 2;

  typedef enum logic [1:0] {IDLE, SEND, GAP, START} tx_state_e;
endpackage

// File: rtl/viterbi_frame_tx_if.sv
// Frame load, symbol stream and status signals between the transmitter and its partner.
interface viterbi_frame_tx_if #(
  parameter int MAX_BITS = 8,
  parameter int LEN_W    = 4
);
  import viterbi_pkg::*;

  logic                load_valid;
  logic                load_ready;
  logic [MAX_BITS-1:0] load_data;
  logic [LEN_W-1:0]    load_len;
  logic [SYM_W-1:0]    sym_data;
  logic                sym_valid;
  logic                sym_ready;
  logic                dec_start;
  logic                busy;
  logic                frame_done;

  modport master (
    input  load_valid, load_data, load_len, sym_ready,
    output load_ready, sym_data, sym_valid, dec_start, busy, frame_done
  );

  modport slave (
    output load_valid, load_data, load_len, sym_ready,
    input  load_ready, sym_data, sym_valid, dec_start, busy, frame_done
  );
endinterface

// File: rtl/viterbi_frame_tx_conv_enc_core.sv
// Rate-1/2 K=3 convolutional encoder: 2-bit state, symbol formed combinationally
// from {s1, s0, b} and the shared generator taps.
module conv_enc_core
  import viterbi_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_bit,
  input  logic             i_advance,
  input  logic             i_clear,
  output logic [SYM_W-1:0] o_sym
);
  logic [K-2:0] r_state;
  logic [K-1:0] w_reg;

  assign w_reg = {r_state, i_bit};
  assign o_sym = {^(G0 & w_reg), ^(G1 & w_reg)};

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_state <= '0;
    end else if (i_advance) begin
      r_state <= {r_state[0], i_bit};
    end
  end
endmodule

// File: rtl/viterbi_frame_tx.sv
// Frame encoder/transmitter feeding the decoder rx port, then pulsing dec_start.
// IDLE wait for load | SEND offer symbol | GAP forced idle after transfer | START dec_start pulse
module viterbi_frame_tx
  import viterbi_pkg::*;
#(
  parameter int MAX_BITS   = 8,
  parameter int LEN_W      = 4,
  parameter int TAIL_EN    = 0,
  parameter int GAP_CYCLES = 3
) (
  input  logic i_clk,
  input  logic i_rst,
  viterbi_frame_tx_if.master bus
);
  localparam int REM_W = LEN_W + 1;
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [REM_W-1:0] TAIL_N = (TAIL_EN != 0) ? REM_W'(2) : '0;

  tx_state_e           r_state;
  logic [MAX_BITS-1:0] r_shift;
  logic [REM_W-1:0]    r_remain;
  logic [GAP_W-1:0]    r_gap;
  logic                r_sym_valid;
  logic                r_dec_start;
  logic                r_frame_done;
  logic                r_busy;
  logic                r_load_ready;

  logic                w_accept;
  logic                w_xfer;
  logic                w_last;
  logic [LEN_W-1:0]    w_len;
  logic [MAX_BITS-1:0] w_mask;
  logic [REM_W-1:0]    w_total;
  logic [SYM_W-1:0]    w_sym;

  assign w_accept = bus.load_valid && r_load_ready;
  assign w_xfer   = r_sym_valid && bus.sym_ready;
  assign w_len    = (bus.load_len > LEN_W'(MAX_BITS)) ? LEN_W'(MAX_BITS) : bus.load_len;
  // Bits above the length are cleared so tail bits shift in as zero.
  assign w_mask   = ~({MAX_BITS{1'b1}} << w_len);
  assign w_total  = REM_W'(w_len) + TAIL_N;
  assign w_last   = (r_remain == REM_W'(1));

  conv_enc_core u_enc (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_bit     (r_shift[0]),
    .i_advance (w_xfer),
    .i_clear   (w_accept),
    .o_sym     (w_sym)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= IDLE;
      r_shift      <= '0;
      r_remain     <= '0;
      r_gap        <= '0;
      r_sym_valid  <= 1'b0;
      r_dec_start  <= 1'b0;
      r_frame_done <= 1'b0;
      r_busy       <= 1'b0;
      r_load_ready <= 1'b1;
    end else begin
      r_dec_start  <= 1'b0;
      r_frame_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_shift      <= bus.load_data & w_mask;
            r_remain     <= w_total;
            r_busy       <= 1'b1;
            r_load_ready <= 1'b0;
            if (w_total == '0) begin
              r_state      <= START;
              r_dec_start  <= 1'b1;
              r_frame_done <= 1'b1;
            end else begin
              r_state     <= SEND;
              r_sym_valid <= 1'b1;
            end
          end
        end
        SEND: begin
          if (w_xfer) begin
            r_shift  <= r_shift >> 1;
            r_remain <= r_remain - REM_W'(1);
            if (GAP_CYCLES > 0) begin
              r_state     <= GAP;
              r_sym_valid <= 1'b0;
              r_gap       <= GAP_W'(GAP_CYCLES - 1);
            end else if (w_last) begin
              r_state      <= START;
              r_sym_valid  <= 1'b0;
              r_dec_start  <= 1'b1;
              r_frame_done <= 1'b1;
            end
          end
        end
        GAP: begin
          if (r_gap == '0) begin
            if (r_remain == '0) begin
              r_state      <= START;
              r_dec_start  <= 1'b1;
              r_frame_done <= 1'b1;
            end else begin
              r_state     <= SEND;
              r_sym_valid <= 1'b1;
            end
          end else begin
            r_gap <= r_gap - GAP_W'(1);
          end
        end
        START: begin
          r_state      <= IDLE;
          r_busy       <= 1'b0;
          r_load_ready <= 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.load_ready = r_load_ready;
  assign bus.sym_valid  = r_sym_valid;
  assign bus.sym_data   = r_sym_valid ? w_sym : '0;
  assign bus.dec_start  = r_dec_start;
  assign bus.frame_done = r_frame_done;
  assign bus.busy       = r_busy | w_accept;
endmodule

// File: tb/tb_viterbi_frame_tx.sv
// Scoreboard bench for viterbi_frame_tx: three instances (gap 3, gap 3 with tail, gap 0).
module tb_viterbi_frame_tx;
  typedef struct {
    int inst;
    int val;
    int gap;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] lv = '0;
  logic [7:0] load_data = '0;
  logic [3:0] load_len = '0;
  logic       sym_ready = 1'b1;

  logic       m_valid [3];
  logic       m_start [3];
  logic       m_done  [3];
  logic       m_busy  [3];
  logic       m_lready[3];
  logic [1:0] m_data  [3];

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   xfer_cnt = 0;
  int   deadline = 0;
  int   last[3] = '{0, 0, 0};
  int   chk_idle = -1;
  int   chk_busy = -1;
  bit   chk_stall = 1'b0;
  int   base;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    viterbi_frame_tx_if #(.MAX_BITS(8), .LEN_W(4)) bus ();
    assign bus.load_valid = lv[g];
    assign bus.load_data  = load_data;
    assign bus.load_len   = load_len;
    assign bus.sym_ready  = sym_ready;

    viterbi_frame_tx #(
      .MAX_BITS   (8),
      .LEN_W      (4),
      .TAIL_EN    ((g == 1) ? 1 : 0),
      .GAP_CYCLES ((g == 2) ? 0 : 3)
    ) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus.master)
    );

    assign m_valid[g]  = bus.sym_valid;
    assign m_start[g]  = bus.dec_start;
    assign m_done[g]   = bus.frame_done;
    assign m_busy[g]   = bus.busy;
    assign m_lready[g] = bus.load_ready;
    assign m_data[g]   = bus.sym_data;
  end

  // val 0..3 = symbol, 4 = dec_start with frame_done and busy all high
  task automatic score(input int i, input int val);
    exp_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event inst %0d got %0d want none", i, val);
      return;
    end
    e = exp_q.pop_front();
    if (e.inst != i || e.val != val || (e.gap >= 0 && (cyc - last[i]) != e.gap)) begin
      errors++;
      $display("FAIL event inst %0d got val %0d gap %0d want inst %0d val %0d gap %0d",
               i, val, cyc - last[i], e.inst, e.val, e.gap);
    end
    last[i] = cyc;
  endtask

  always @(negedge clk) begin
    cyc++;
    for (int i = 0; i < 3; i++) begin
      if (lv[i] && m_lready[i]) last[i] = cyc;
      if (m_valid[i] && sym_ready) begin
        xfer_cnt++;
        score(i, int'(m_data[i]));
      end
      if (m_start[i] || m_done[i]) begin
        if (m_start[i] && m_done[i] && m_busy[i]) score(i, 4);
        else score(i, 8 + int'({m_start[i], m_done[i], m_busy[i]}));
      end
      if (chk_idle == i) begin
        checks++;
        if ({m_lready[i], m_valid[i], m_data[i], m_start[i], m_busy[i], m_done[i]} !== 7'b1000000) begin
          errors++;
          $display("FAIL idle_state inst %0d got %b want 1000000", i,
                   {m_lready[i], m_valid[i], m_data[i], m_start[i], m_busy[i], m_done[i]});
        end
      end
      if (chk_busy == i) begin
        checks++;
        if ({m_lready[i], m_busy[i]} !== 2'b01) begin
          errors++;
          $display("FAIL busy_ignore inst %0d got %b want 01", i, {m_lready[i], m_busy[i]});
        end
      end
    end
    if (chk_stall) begin
      checks++;
      if ({m_valid[0], m_data[0]} !== 3'b100) begin
        errors++;
        $display("FAIL stall_hold got %b want 100", {m_valid[0], m_data[0]});
      end
    end
    if (exp_q.size() != 0 && cyc > deadline) begin
      checks++;
      errors++;
      $display("FAIL timeout got %0d pending want 0", exp_q.size());
      exp_q.delete();
    end
  end

  task automatic push(input int i, input int v, input int g);
    exp_t e;
    e.inst = i;
    e.val  = v;
    e.gap  = g;
    exp_q.push_back(e);
  endtask

  // syms packs symbol k at bits [2k+1:2k]; gap is the instance GAP_CYCLES
  task automatic expect_frame(input int i, input logic [15:0] syms, input int n,
                              input int gap, input int stall_idx, input bit with_start);
    for (int k = 0; k < n; k++)
      push(i, int'(syms[2*k +: 2]), (k == 0) ? 1 : ((k == stall_idx) ? -1 : gap + 1));
    if (with_start) push(i, 4, (n == 0) ? 1 : gap + 1);
    deadline = cyc + 300;
  endtask

  task automatic load(input int i, input logic [7:0] d, input logic [3:0] len);
    @(posedge clk); #1;
    lv[i] = 1'b1;
    load_data = d;
    load_len = len;
    @(posedge clk); #1;
    lv[i] = 1'b0;
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 400 && exp_q.size() != 0; k++) @(posedge clk);
    #1;
  endtask

  task automatic wait_xfers(input int target);
    for (int k = 0; k < 300 && xfer_cnt < target; k++) @(posedge clk);
    #1;
  endtask

  task automatic idle_check(input int i);
    chk_idle = i;
    @(negedge clk); #1;
    chk_idle = -1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 3; i++) idle_check(i);

    // 0x2D, 8 bits, gap 3
    expect_frame(0, 16'hE14B, 8, 3, -1, 1'b1);
    load(0, 8'h2D, 4'd8);
    wait_drain();
    idle_check(0);

    // 0x01, 1 bit plus two tail bits
    expect_frame(1, 16'h003B, 3, 3, -1, 1'b1);
    load(1, 8'h01, 4'd1);
    wait_drain();
    idle_check(1);

    // 0xFF, 2 bits: upper data bits must not leak into the tail
    expect_frame(1, 16'h00D7, 4, 3, -1, 1'b1);
    load(1, 8'hFF, 4'd2);
    wait_drain();

    // sym_ready held low for 10 cycles while symbol 3 (00) is offered
    base = xfer_cnt;
    expect_frame(0, 16'hE14B, 8, 3, 2, 1'b1);
    load(0, 8'h2D, 4'd8);
    wait_xfers(base + 2);
    sym_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk_stall = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk_stall = 1'b0;
    sym_ready = 1'b1;
    wait_drain();
    idle_check(0);

    // empty frame: dec_start one cycle after accept
    expect_frame(0, 16'h0000, 0, 3, -1, 1'b1);
    load(0, 8'hFF, 4'd0);
    wait_drain();
    idle_check(0);

    // length 12 clamps to 8
    expect_frame(0, 16'h2F8B, 8, 3, -1, 1'b1);
    load(0, 8'hA5, 4'd12);
    wait_drain();

    // reset after the 4th transfer, then a clean repeat of the first frame
    base = xfer_cnt;
    expect_frame(0, 16'hE14B, 4, 3, -1, 1'b0);
    load(0, 8'h2D, 4'd8);
    wait_xfers(base + 4);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    idle_check(0);
    repeat (12) @(posedge clk);
    #1;
    expect_frame(0, 16'hE14B, 8, 3, -1, 1'b1);
    load(0, 8'h2D, 4'd8);
    wait_drain();
    idle_check(0);

    // gap 0: back-to-back symbols, mid-frame load ignored
    base = xfer_cnt;
    expect_frame(2, 16'hE14B, 8, 0, -1, 1'b1);
    load(2, 8'h2D, 4'd8);
    wait_xfers(base + 3);
    lv[2] = 1'b1;
    load_data = 8'hFF;
    chk_busy = 2;
    @(posedge clk); #1;
    @(posedge clk); #1;
    lv[2] = 1'b0;
    chk_busy = -1;
    wait_drain();
    idle_check(2);

    repeat (5) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
